// File: rtl/reg_file_2r1w.sv
// 32x32 general-purpose register file feeding the ALU: two combinational read
// ports, one synchronous write port, optional write-to-read bypass, 2-bit flags.
module reg_file_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R_addr_A,
  input  logic [ADDR_W-1:0] R_addr_B,
  output logic [DATA_W-1:0] rdata_A,
  output logic [DATA_W-1:0] rdata_B,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  input  logic              L_S,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              flag_we,
  output logic [1:0]        flags,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Register 0 has no storage; reads of it are forced to zero below.
  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [1:0]        flags_q;
  logic [1:0]        flags_d;
  logic              wr_en;

  assign wr_en = L_S && (Wt_addr != '0) && !rst;

  always_comb begin
    flags_d = flags_q;
    if (flag_we) flags_d = {alu_overflow, alu_zero};
  end

  // NOTE: the storage array is cleared by reset here because every register must
  // read 0 after reset; a RAM macro could not be used with this behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < DEPTH; i++) regs_q[i] <= '0;
      flags_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (wr_en) regs_q[Wt_addr] <= Wt_data;
      flags_q <= flags_d;
    end
  end

  logic [DATA_W-1:0] stored_a, stored_b;
  logic              bypass_a, bypass_b;

  // NOTE: each always_comb output gets a default first so no path infers a latch.
  always_comb begin
    stored_a = '0;
    stored_b = '0;
    dbg_data = '0;
    if (R_addr_A != '0) stored_a = regs_q[R_addr_A];
    if (R_addr_B != '0) stored_b = regs_q[R_addr_B];
    if (dbg_addr != '0) dbg_data = regs_q[dbg_addr];
  end

  // wr_en already excludes r0 and reset, so bypass never forwards a dropped write.
  assign bypass_a = (BYPASS != 0) && wr_en && (R_addr_A == Wt_addr);
  assign bypass_b = (BYPASS != 0) && wr_en && (R_addr_B == Wt_addr);

  assign rdata_A = bypass_a ? Wt_data : stored_a;
  assign rdata_B = bypass_b ? Wt_data : stored_b;
  assign flags   = flags_q;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Self-checking bench for reg_file_2r1w: directed scenarios plus randomized traffic
// against an array-based model, with a bypassed and a non-bypassed instance.
module tb_reg_file_2r1w;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] R_addr_A, R_addr_B, Wt_addr, dbg_addr;
  logic [DATA_W-1:0] Wt_data;
  logic              L_S, alu_zero, alu_overflow, flag_we;
  logic [DATA_W-1:0] rdata_A, rdata_B, dbg_data;
  logic [DATA_W-1:0] rdata_A_nb, rdata_B_nb, dbg_data_nb;
  logic [1:0]        flags, flags_nb;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        flags_m;

  always #5 clk = ~clk;

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .rdata_A(rdata_A), .rdata_B(rdata_B), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .L_S(L_S), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .flag_we(flag_we),
    .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .R_addr_A(R_addr_A), .R_addr_B(R_addr_B),
    .rdata_A(rdata_A_nb), .rdata_B(rdata_B_nb), .Wt_addr(Wt_addr), .Wt_data(Wt_data),
    .L_S(L_S), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .flag_we(flag_we),
    .flags(flags_nb), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb)
  );

  // Expected read value given the current inputs and model contents.
  function automatic logic [DATA_W-1:0] exp_rd(input logic [ADDR_W-1:0] addr, input bit byp);
    if (addr == 0) return '0;
    if (byp && !rst && L_S && Wt_addr == addr) return Wt_data;
    return mem[addr];
  endfunction

  // Apply the pending edge to the model, then advance past the edge.
  task automatic step();
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      flags_m = 2'b00;
    end else begin
      if (L_S && Wt_addr != 0) mem[Wt_addr] = Wt_data;
      if (flag_we) flags_m = {alu_overflow, alu_zero};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; L_S = 1'b0; flag_we = 1'b0; alu_zero = 1'b0; alu_overflow = 1'b0;
    Wt_addr = '0; Wt_data = '0; R_addr_A = '0; R_addr_B = '0; dbg_addr = '0;
  endtask

  task automatic test_reset();
    set_idle(); rst = 1'b1; step();
    set_idle(); L_S = 1'b1; Wt_addr = 5'd5; Wt_data = 32'hFFFF_FFFF; step();
    set_idle(); R_addr_A = 5'd5; #1;
    checks++; if (rdata_A !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL reset_prewrite: got %h exp %h", rdata_A, 32'hFFFF_FFFF); end
    rst = 1'b1; L_S = 1'b1; Wt_addr = 5'd6; Wt_data = 32'h1234_5678;
    flag_we = 1'b1; alu_zero = 1'b1; alu_overflow = 1'b1; R_addr_A = 5'd6; #1;
    checks++; if (rdata_A !== 32'h0) begin errors++;
      $display("FAIL reset_no_bypass: got %h exp %h", rdata_A, 32'h0); end
    step(); set_idle();
    for (int a = 0; a < DEPTH; a++) begin
      R_addr_A = a[ADDR_W-1:0]; R_addr_B = a[ADDR_W-1:0]; dbg_addr = a[ADDR_W-1:0]; #1;
      checks++;
      if (rdata_A !== 0 || rdata_B !== 0 || dbg_data !== 0) begin errors++;
        $display("FAIL reset_clear r%0d: got A=%h B=%h dbg=%h exp 0", a, rdata_A, rdata_B, dbg_data); end
    end
    checks++; if (flags !== 2'b00) begin errors++;
      $display("FAIL reset_flags: got %b exp 00", flags); end
  endtask

  task automatic test_basic();
    set_idle(); L_S = 1'b1; Wt_addr = 5'd1; Wt_data = 32'hA5A5_A5A5; step();
    Wt_addr = 5'd2; Wt_data = 32'h5A5A_5A5A; step();
    set_idle(); R_addr_A = 5'd1; R_addr_B = 5'd2; dbg_addr = 5'd2; #1;
    checks++; if (rdata_A !== 32'hA5A5_A5A5) begin errors++;
      $display("FAIL basic_a: got %h exp %h", rdata_A, 32'hA5A5_A5A5); end
    checks++; if (rdata_B !== 32'h5A5A_5A5A) begin errors++;
      $display("FAIL basic_b: got %h exp %h", rdata_B, 32'h5A5A_5A5A); end
    checks++; if (dbg_data !== 32'h5A5A_5A5A) begin errors++;
      $display("FAIL basic_dbg: got %h exp %h", dbg_data, 32'h5A5A_5A5A); end
  endtask

  task automatic test_r0();
    set_idle(); L_S = 1'b1; Wt_addr = 5'd0; Wt_data = 32'h0123_4567; #1;
    checks++; if (rdata_A !== 0 || rdata_A_nb !== 0) begin errors++;
      $display("FAIL r0_pre: got %h/%h exp 0", rdata_A, rdata_A_nb); end
    step(); set_idle(); #1;
    checks++; if (rdata_A !== 0 || dbg_data !== 0) begin errors++;
      $display("FAIL r0_post: got A=%h dbg=%h exp 0", rdata_A, dbg_data); end
  endtask

  task automatic test_bypass();
    set_idle(); L_S = 1'b1; Wt_addr = 5'd3; Wt_data = 32'h1111_1111; step();
    Wt_data = 32'h7654_3210; R_addr_A = 5'd3; R_addr_B = 5'd3; dbg_addr = 5'd3; #1;
    checks++; if (rdata_A !== 32'h7654_3210 || rdata_B !== 32'h7654_3210) begin errors++;
      $display("FAIL bypass_ab: got %h/%h exp %h", rdata_A, rdata_B, 32'h7654_3210); end
    checks++; if (dbg_data !== 32'h1111_1111) begin errors++;
      $display("FAIL bypass_dbg: got %h exp %h", dbg_data, 32'h1111_1111); end
    checks++; if (rdata_A_nb !== 32'h1111_1111 || rdata_B_nb !== 32'h1111_1111) begin errors++;
      $display("FAIL nobypass_pre: got %h/%h exp %h", rdata_A_nb, rdata_B_nb, 32'h1111_1111); end
    step(); L_S = 1'b0; #1;
    checks++; if (rdata_A_nb !== 32'h7654_3210 || rdata_B_nb !== 32'h7654_3210) begin errors++;
      $display("FAIL nobypass_post: got %h/%h exp %h", rdata_A_nb, rdata_B_nb, 32'h7654_3210); end
  endtask

  task automatic test_flags();
    set_idle(); flag_we = 1'b1; alu_zero = 1'b1; alu_overflow = 1'b0; step();
    checks++; if (flags !== 2'b01) begin errors++;
      $display("FAIL flags_cap: got %b exp 01", flags); end
    flag_we = 1'b0; alu_zero = 1'b1; alu_overflow = 1'b1; step();
    checks++; if (flags !== 2'b01) begin errors++;
      $display("FAIL flags_hold: got %b exp 01", flags); end
    flag_we = 1'b1; step();
    checks++; if (flags !== 2'b11) begin errors++;
      $display("FAIL flags_11: got %b exp 11", flags); end
  endtask

  task automatic test_simultaneous();
    set_idle(); L_S = 1'b1; Wt_addr = 5'd7; Wt_data = 32'hDEAD_BEEF;
    flag_we = 1'b1; alu_overflow = 1'b1; alu_zero = 1'b0; step();
    set_idle(); R_addr_A = 5'd7; #1;
    checks++; if (rdata_A !== 32'hDEAD_BEEF || flags !== 2'b10) begin errors++;
      $display("FAIL simultaneous: got %h/%b exp %h/10", rdata_A, flags, 32'hDEAD_BEEF); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 24) == 0);
      L_S          = $urandom_range(0, 1);
      flag_we      = $urandom_range(0, 1);
      alu_zero     = $urandom_range(0, 1);
      alu_overflow = $urandom_range(0, 1);
      Wt_addr      = $urandom_range(0, DEPTH - 1);
      Wt_data      = $urandom;
      R_addr_A     = ($urandom_range(0, 2) == 0) ? Wt_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      R_addr_B     = ($urandom_range(0, 2) == 0) ? Wt_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      dbg_addr     = ($urandom_range(0, 2) == 0) ? Wt_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
      #1;
      checks++; if (rdata_A !== exp_rd(R_addr_A, 1)) begin errors++;
        $display("FAIL rand_a #%0d: got %h exp %h", n, rdata_A, exp_rd(R_addr_A, 1)); end
      checks++; if (rdata_B !== exp_rd(R_addr_B, 1)) begin errors++;
        $display("FAIL rand_b #%0d: got %h exp %h", n, rdata_B, exp_rd(R_addr_B, 1)); end
      checks++; if (dbg_data !== exp_rd(dbg_addr, 0)) begin errors++;
        $display("FAIL rand_dbg #%0d: got %h exp %h", n, dbg_data, exp_rd(dbg_addr, 0)); end
      checks++; if (rdata_A_nb !== exp_rd(R_addr_A, 0) || rdata_B_nb !== exp_rd(R_addr_B, 0)) begin errors++;
        $display("FAIL rand_nb #%0d: got %h/%h exp %h/%h", n, rdata_A_nb, rdata_B_nb,
                 exp_rd(R_addr_A, 0), exp_rd(R_addr_B, 0)); end
      checks++; if (flags !== flags_m || flags_nb !== flags_m) begin errors++;
        $display("FAIL rand_flags #%0d: got %b/%b exp %b", n, flags, flags_nb, flags_m); end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    flags_m = 2'b00;
    test_reset();
    test_basic();
    test_r0();
    test_bypass();
    test_flags();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- 32 x 32-bit general-purpose register file directly upstream of the ALU. Read port A drives ALU input A; read port B drives ALU input B.
- One synchronous write port accepts the write-back result.
- Optional same-cycle write-to-read bypass.
- 2-bit flag register captures the ALU's zero/overflow outputs from the downstream stage for branch logic and debug.

Parameters:
- DATA_W, 32, width of each register and of every data port.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = a read of the address being written returns the new data in the same cycle; 0 = the read returns the old contents.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- R_addr_A  input  ADDR_W  read address, port A.
- R_addr_B  input  ADDR_W  read address, port B.
- rdata_A  output  DATA_W  port A read data (to ALU input A).
- rdata_B  output  DATA_W  port B read data (to ALU input B).
- Wt_addr  input  ADDR_W  write address.
- Wt_data  input  DATA_W  write data (ALU res or load data).
- L_S  input  1  write enable, 1 = write.
- alu_zero  input  1  ALU zero output.
- alu_overflow  input  1  ALU overflow output.
- flag_we  input  1  capture enable for flags.
- flags  output  2  registered {overflow, zero}.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data, combinational, never bypassed.

Behaviour:
- Storage: registers 1 to 2**ADDR_W-1. Register 0 is not stored: it always reads 0, and writes to address 0 are silently dropped.
- Reset: rising edge with rst=1 clears all registers and flags to 0 in one cycle.
  - After that edge, rdata_A, rdata_B, dbg_data = 0 for every address, and flags = 2'b00.
  - rst has priority over L_S and flag_we in the same cycle; the write is lost.
- Reset mid-sequence: no partial state survives. The first write accepted after reset is the one on the first edge with rst=0.
- Read ports A, B, debug: purely combinational from current storage, zero latency.
- Write: on the rising edge with rst=0, L_S=1 and Wt_addr != 0, reg[Wt_addr] <= Wt_data. The new value is visible on non-bypassed reads after that edge.
- Bypass (BYPASS=1): while L_S=1, Wt_addr != 0 and R_addr_X == Wt_addr, rdata_X = Wt_data combinationally.
  - Applies to ports A and B independently; both may bypass simultaneously.
  - Suppressed when rst=1, since the write will not commit.
  - Never applies to dbg_data.
- BYPASS=0: rdata_X shows old contents until the edge.
- Same-address reads: R_addr_A == R_addr_B returns identical data on both ports.
- Flags: on the rising edge with rst=0 and flag_we=1, flags <= {alu_overflow, alu_zero}; otherwise flags hold.
  - Flag capture is independent of L_S and can occur in the same cycle as a register write.
- Address width: addresses are unsigned and exact width; no wrap logic is needed beyond ADDR_W bits.
- Implementation constraints: no X on any output after the first reset edge; no combinational path from clk to outputs.

Test Plan:
- Reset clear: write 0xFFFFFFFF to r5, then assert rst for 1 cycle with L_S=1, Wt_addr=6, Wt_data=0x12345678 -> after the edge, r5=0, r6=0, flags=00.
- Basic write/read: write 0xA5A5A5A5 to r1 and 0x5A5A5A5A to r2, then R_addr_A=1, R_addr_B=2 -> rdata_A=0xA5A5A5A5, rdata_B=0x5A5A5A5A, dbg_addr=2 gives 0x5A5A5A5A.
- r0 hardwired: L_S=1, Wt_addr=0, Wt_data=0x01234567 -> rdata_A (R_addr_A=0) = 0 before and after the edge; no bypass on r0.
- Bypass: r3=0x11111111, then L_S=1, Wt_addr=3, Wt_data=0x76543210, R_addr_A=R_addr_B=3 -> both ports read 0x76543210 before the edge and dbg_data=0x11111111; with BYPASS=0 both ports read 0x11111111 until the edge.
- Flags: alu_zero=1, alu_overflow=0, flag_we=1 -> flags=01 after the edge; change inputs to 1/1 with flag_we=0 -> flags stay 01; flag_we=1 -> flags=11.
- Simultaneous: same edge writes r7=0xDEADBEEF and captures flags=10 -> both updates are visible after a single edge.
